// File: rtl/nf10_param_output_queues_pkg.sv
// Shared definitions for the parametrised output-queue stage: tuser field layout
// and the input packet state machine encoding.
package nf10_oq_pkg;

    localparam int TUSER_LEN_LSB   = 0;
    localparam int TUSER_LEN_WIDTH = 16;
    localparam int TUSER_SRC_LSB   = 16;
    localparam int TUSER_SRC_WIDTH = 8;
    localparam int TUSER_DST_LSB   = 24;
    localparam int TUSER_DST_WIDTH = 8;

    localparam int DST_POS_DEFAULT = TUSER_DST_LSB;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } in_state_e;

endpackage

// File: rtl/nf10_param_output_queues_chk.sv
// Protocol checker for the output-queue stage: flags packets longer than the
// admission threshold, which get truncated inside a queue.
module oq_protocol_chk #(
    parameter int NUM_QUEUES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_QUEUES-1:0] wr_en,
    input  logic [NUM_QUEUES-1:0] last_slot,
    input  logic                  tlast
);

    a_pkt_fits_queue: assert property (@(posedge clk) disable iff (rst)
        (((wr_en & last_slot) == '0) || tlast));

endmodule

// File: rtl/nf10_param_output_queues_fifo.sv
// First-word-fall-through queue with extra-msb pointers; head word is visible one
// cycle after it is written and free_words reports remaining capacity.
module oq_fwft_fifo #(
    parameter int WIDTH      = 418,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   free_words
);

    localparam logic [DEPTH_LOG2:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PTR_ONE     = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_r [2**DEPTH_LOG2];
    logic [DEPTH_LOG2:0]   wptr_r;
    logic [DEPTH_LOG2:0]   rptr_r;
    logic [DEPTH_LOG2:0]   used_s;
    logic                  full_s;
    logic                  pop_s;
    logic                  push_s;

    assign used_s     = wptr_r - rptr_r;
    assign full_s     = used_s[DEPTH_LOG2];
    assign empty      = (used_s == '0);
    assign pop_s      = rd_en && !empty;
    // When full, a write is only taken together with a pop so the slot is reused.
    assign push_s     = wr_en && (!full_s || pop_s);
    assign free_words = DEPTH_WORDS - used_s;
    assign rd_data    = mem_r[rptr_r[DEPTH_LOG2-1:0]];

    // Storage array, written at the tail pointer.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

    // Head and tail pointers; reset flushes the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= '0;
            rptr_r <= '0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/nf10_param_output_queues.sv
// One AXI4-Stream input demultiplexed into NUM_QUEUES FWFT output queues by the
// one-hot dst field, with per-packet store-and-drop admission and statistics.
module nf10_param_output_queues
    import nf10_oq_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES    = 5,
    parameter int DST_POS       = DST_POS_DEFAULT,
    parameter int DEPTH_LOG2    = 9,
    parameter int MAX_PKT_WORDS = 64,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                                   axi_aclk,
    input  logic                                   axi_reset,
    input  logic [C_DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0]              s_axis_tstrb,
    input  logic [C_TUSER_WIDTH-1:0]               s_axis_tuser,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,
    output logic [NUM_QUEUES*C_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [NUM_QUEUES*C_DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [NUM_QUEUES*C_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic [NUM_QUEUES-1:0]                  m_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                  m_axis_tready,
    output logic [NUM_QUEUES-1:0]                  m_axis_tlast,
    input  logic                                   stat_clear,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]        pkt_stored_cnt,
    output logic [NUM_QUEUES*CNT_WIDTH-1:0]        pkt_dropped_cnt
);

    localparam int STRB_WIDTH = C_DATA_WIDTH / 8;
    localparam int FIFO_WIDTH = C_DATA_WIDTH + STRB_WIDTH + C_TUSER_WIDTH + 1;
    localparam int PTR_W      = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    in_state_e             state_r;
    in_state_e             next_state_s;
    logic                  s_ready_r;
    logic                  beat_s;
    logic                  sop_s;
    logic [NUM_QUEUES-1:0] dst_s;
    logic [NUM_QUEUES-1:0] admit_s;
    logic [NUM_QUEUES-1:0] wr_mask_r;
    logic [NUM_QUEUES-1:0] trunc_r;
    logic [NUM_QUEUES-1:0] trunc_next_s;
    logic [NUM_QUEUES-1:0] wr_en_s;
    logic [NUM_QUEUES-1:0] last_slot_s;

    assign s_axis_tready = s_ready_r;
    assign beat_s        = s_axis_tvalid && s_ready_r;
    assign sop_s         = beat_s && (state_r == IDLE);
    assign dst_s         = s_axis_tuser[DST_POS +: NUM_QUEUES];

    // Input ready is low only while in reset; admission never back-pressures.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            s_ready_r <= 1'b0;
        end else begin
            s_ready_r <= 1'b1;
        end
    end

    // Packet state register.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Packet boundary tracking; a single-beat packet never leaves IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (beat_s && !s_axis_tlast) begin
                    next_state_s = WR_PKT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WR_PKT: begin
                if (beat_s && s_axis_tlast) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WR_PKT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Truncation flags restart at every SOP and clear when the packet ends.
    always_comb begin
        trunc_next_s = trunc_r;
        if (s_axis_tlast) begin
            trunc_next_s = '0;
        end else if (sop_s) begin
            trunc_next_s = wr_en_s & last_slot_s;
        end else begin
            trunc_next_s = trunc_r | (wr_en_s & last_slot_s);
        end
    end

    // Admission mask is held for the rest of the packet after the SOP decision.
    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            wr_mask_r <= '0;
            trunc_r   <= '0;
        end else if (beat_s) begin
            if (sop_s) begin
                wr_mask_r <= admit_s;
            end
            trunc_r <= trunc_next_s;
        end
    end

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        logic [PTR_W-1:0]      free_words_s;
        logic                  empty_s;
        logic [FIFO_WIDTH-1:0] wr_data_s;
        logic [FIFO_WIDTH-1:0] rd_data_s;
        logic [CNT_WIDTH-1:0]  stored_r;
        logic [CNT_WIDTH-1:0]  dropped_r;

        assign admit_s[q]     = dst_s[q] && (32'(free_words_s) >= 32'(MAX_PKT_WORDS));
        assign last_slot_s[q] = (free_words_s == PTR_ONE);
        assign wr_en_s[q]     = beat_s && (sop_s ? admit_s[q] : (wr_mask_r[q] && !trunc_r[q]));
        // An over-long packet is closed off in the queue's final slot.
        assign wr_data_s      = {s_axis_tlast | last_slot_s[q], s_axis_tuser, s_axis_tstrb, s_axis_tdata};

        oq_fwft_fifo #(
            .WIDTH      (FIFO_WIDTH),
            .DEPTH_LOG2 (DEPTH_LOG2)
        ) u_fifo (
            .clk        (axi_aclk),
            .rst        (axi_reset),
            .wr_en      (wr_en_s[q]),
            .wr_data    (wr_data_s),
            .rd_en      (m_axis_tready[q]),
            .rd_data    (rd_data_s),
            .empty      (empty_s),
            .free_words (free_words_s)
        );

        assign m_axis_tvalid[q]                                = !empty_s;
        assign m_axis_tdata[q*C_DATA_WIDTH +: C_DATA_WIDTH]    = rd_data_s[C_DATA_WIDTH-1:0];
        assign m_axis_tstrb[q*STRB_WIDTH +: STRB_WIDTH]        = rd_data_s[C_DATA_WIDTH +: STRB_WIDTH];
        assign m_axis_tuser[q*C_TUSER_WIDTH +: C_TUSER_WIDTH]  = rd_data_s[C_DATA_WIDTH+STRB_WIDTH +: C_TUSER_WIDTH];
        assign m_axis_tlast[q]                                 = rd_data_s[FIFO_WIDTH-1];

        // Per-queue statistics; a clear wins over an increment in the same cycle.
        always_ff @(posedge axi_aclk or posedge axi_reset) begin
            if (axi_reset) begin
                stored_r  <= '0;
                dropped_r <= '0;
            end else if (stat_clear) begin
                stored_r  <= '0;
                dropped_r <= '0;
            end else if (sop_s) begin
                if (admit_s[q]) begin
                    stored_r <= stored_r + CNT_ONE;
                end else if (dst_s[q]) begin
                    dropped_r <= dropped_r + CNT_ONE;
                end
            end
        end

        assign pkt_stored_cnt[q*CNT_WIDTH +: CNT_WIDTH]  = stored_r;
        assign pkt_dropped_cnt[q*CNT_WIDTH +: CNT_WIDTH] = dropped_r;
    end

    oq_protocol_chk #(
        .NUM_QUEUES (NUM_QUEUES)
    ) u_chk (
        .clk        (axi_aclk),
        .rst        (axi_reset),
        .wr_en      (wr_en_s),
        .last_slot  (last_slot_s),
        .tlast      (s_axis_tlast)
    );

endmodule

// File: tb/tb_nf10_param_output_queues.sv
// Scoreboard bench for nf10_param_output_queues: expected beats are queued per
// output port when driven and compared as each port hands a beat over.
module tb_nf10_param_output_queues;
    import nf10_oq_pkg::*;

    localparam int NQ    = 5;
    localparam int DW    = 256;
    localparam int SW    = DW / 8;
    localparam int TW    = 128;
    localparam int DL    = 7;
    localparam int DEPTH = 2 ** DL;
    localparam int MAXW  = 64;
    localparam int CW    = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [TW-1:0] user;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_axis_tdata;
    logic [SW-1:0]     s_axis_tstrb;
    logic [TW-1:0]     s_axis_tuser;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              s_axis_tlast;
    logic [NQ*DW-1:0]  m_axis_tdata;
    logic [NQ*SW-1:0]  m_axis_tstrb;
    logic [NQ*TW-1:0]  m_axis_tuser;
    logic [NQ-1:0]     m_axis_tvalid;
    logic [NQ-1:0]     m_axis_tready;
    logic [NQ-1:0]     m_axis_tlast;
    logic              stat_clear;
    logic [NQ*CW-1:0]  pkt_stored_cnt;
    logic [NQ*CW-1:0]  pkt_dropped_cnt;

    beat_t exp_q [NQ][$];
    int    exp_stored [NQ];
    int    exp_dropped [NQ];
    beat_t mon_exp;
    int    vectors = 0;
    int    miscompares = 0;
    bit    rand_q3 = 1'b0;

    always #5 clk = ~clk;

    nf10_param_output_queues #(
        .C_DATA_WIDTH  (DW),
        .C_TUSER_WIDTH (TW),
        .NUM_QUEUES    (NQ),
        .DST_POS       (TUSER_DST_LSB),
        .DEPTH_LOG2    (DL),
        .MAX_PKT_WORDS (MAXW),
        .CNT_WIDTH     (CW)
    ) dut (
        .axi_aclk        (clk),
        .axi_reset       (rst),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tstrb    (s_axis_tstrb),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tlast    (s_axis_tlast),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tstrb    (m_axis_tstrb),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .stat_clear      (stat_clear),
        .pkt_stored_cnt  (pkt_stored_cnt),
        .pkt_dropped_cnt (pkt_dropped_cnt)
    );

    task automatic chk_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_q3) begin
            m_axis_tready[3] = ($urandom_range(0, 7) != 0);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) begin
            d[k*32 +: 32] = $urandom;
        end
        return d;
    endfunction

    function automatic int model_left();
        int n = 0;
        for (int q = 0; q < NQ; q++) begin
            n += exp_q[q].size();
        end
        return n;
    endfunction

    task automatic clear_model();
        for (int q = 0; q < NQ; q++) begin
            exp_q[q].delete();
            exp_stored[q]  = 0;
            exp_dropped[q] = 0;
        end
    endtask

    task automatic check_counters(input string tag);
        for (int q = 0; q < NQ; q++) begin
            chk_eq($sformatf("%s stored q%0d", tag, q), pkt_stored_cnt[q*CW +: CW], exp_stored[q]);
            chk_eq($sformatf("%s dropped q%0d", tag, q), pkt_dropped_cnt[q*CW +: CW], exp_dropped[q]);
        end
    endtask

    // Drive one packet; exp_mask lists the queues expected to admit it.
    task automatic send_pkt(input logic [7:0] dst, input int len, input logic [NQ-1:0] exp_mask, input logic clr);
        logic [DW-1:0] r;
        logic [TW-1:0] user;
        beat_t         bt;
        r    = rand_data();
        user = r[TW-1:0];
        user[TUSER_LEN_LSB +: TUSER_LEN_WIDTH] = 16'(len * SW);
        user[TUSER_SRC_LSB +: TUSER_SRC_WIDTH] = 8'h01;
        user[TUSER_DST_LSB +: TUSER_DST_WIDTH] = dst;
        for (int b = 0; b < len; b++) begin
            bt.data = rand_data();
            r       = rand_data();
            bt.strb = r[SW-1:0];
            bt.user = user;
            bt.last = (b == len - 1);
            s_axis_tdata  = bt.data;
            s_axis_tstrb  = bt.strb;
            s_axis_tuser  = bt.user;
            s_axis_tlast  = bt.last;
            s_axis_tvalid = 1'b1;
            stat_clear    = (b == 0) ? clr : 1'b0;
            for (int q = 0; q < NQ; q++) begin
                if (exp_mask[q]) begin
                    exp_q[q].push_back(bt);
                end
                if (b == 0) begin
                    if (clr) begin
                        exp_stored[q]  = 0;
                        exp_dropped[q] = 0;
                    end else if (exp_mask[q]) begin
                        exp_stored[q]++;
                    end else if (dst[q]) begin
                        exp_dropped[q]++;
                    end
                end
            end
            chk_eq("s_axis_tready", s_axis_tready, 1'b1);
            step();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        stat_clear    = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (model_left() != 0 && n < 20000) begin
            step();
            n++;
        end
        chk_eq({tag, " drained"}, model_left(), 0);
        step();
        step();
        chk_eq({tag, " no extra beats"}, m_axis_tvalid, '0);
    endtask

    // Output monitor: every handshake must match the head of that queue's scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int q = 0; q < NQ; q++) begin
                if (m_axis_tvalid[q] && m_axis_tready[q]) begin
                    chk_eq($sformatf("q%0d beat expected", q), exp_q[q].size() != 0, 1'b1);
                    if (exp_q[q].size() != 0) begin
                        mon_exp = exp_q[q].pop_front();
                        chk_eq($sformatf("q%0d tdata", q), m_axis_tdata[q*DW +: DW], mon_exp.data);
                        chk_eq($sformatf("q%0d tstrb", q), m_axis_tstrb[q*SW +: SW], mon_exp.strb);
                        chk_eq($sformatf("q%0d tuser", q), m_axis_tuser[q*TW +: TW], mon_exp.user);
                        chk_eq($sformatf("q%0d tlast", q), m_axis_tlast[q], mon_exp.last);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] r;
        beat_t         bt;
        int            n;

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        s_axis_tuser  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        stat_clear    = 1'b0;
        m_axis_tready = '1;
        clear_model();
        step();
        step();
        chk_eq("reset s_axis_tready", s_axis_tready, 1'b0);
        chk_eq("reset tvalid", m_axis_tvalid, '0);
        check_counters("reset");
        rst = 1'b0;
        step();
        chk_eq("post-reset s_axis_tready", s_axis_tready, 1'b1);
        step();

        // Unicast to queue 2.
        send_pkt(8'b0000_0100, 3, 5'b00100, 1'b0);
        wait_drain("unicast");
        check_counters("unicast");

        // Multicast to queues 0, 1 and 4.
        send_pkt(8'b0001_0011, 4, 5'b10011, 1'b0);
        wait_drain("multicast");
        check_counters("multicast");

        // No destination, and destination bits beyond NUM_QUEUES only.
        send_pkt(8'b0000_0000, 2, 5'b00000, 1'b0);
        send_pkt(8'b1110_0000, 2, 5'b00000, 1'b0);
        send_pkt(8'b1110_0000, 1, 5'b00000, 1'b0);
        wait_drain("no dst");
        check_counters("no dst");

        // Clear coinciding with an SOP suppresses that increment.
        send_pkt(8'b0000_0010, 2, 5'b00010, 1'b1);
        wait_drain("clear");
        check_counters("clear");

        // Drop on full queue 1.
        m_axis_tready[1] = 1'b0;
        send_pkt(8'b0000_0010, MAXW, 5'b00010, 1'b0);
        send_pkt(8'b0000_0010, MAXW, 5'b00010, 1'b0);
        send_pkt(8'b0000_0010, MAXW, 5'b00000, 1'b0);
        step();
        check_counters("full q1");
        m_axis_tready[1] = 1'b1;
        wait_drain("full q1");

        // Partial multicast drop: queue 0 full, queue 1 has room.
        m_axis_tready[0] = 1'b0;
        send_pkt(8'b0000_0001, MAXW, 5'b00001, 1'b0);
        send_pkt(8'b0000_0001, MAXW, 5'b00001, 1'b0);
        send_pkt(8'b0000_0011, 3, 5'b00010, 1'b0);
        step();
        check_counters("partial");
        m_axis_tready[0] = 1'b1;
        wait_drain("partial");

        // Back-pressure and pointer wrap on queue 3.
        rand_q3 = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            n = 0;
            while (exp_q[3].size() > DEPTH - MAXW && n < 2000) begin
                step();
                n++;
            end
            chk_eq("q3 room", exp_q[3].size() <= DEPTH - MAXW, 1'b1);
            send_pkt(8'b0000_1000, $urandom_range(1, MAXW), 5'b01000, 1'b0);
        end
        rand_q3 = 1'b0;
        m_axis_tready[3] = 1'b1;
        wait_drain("wrap");
        check_counters("wrap");

        // Reset on beat 2 of a 5-beat packet to queue 0.
        r  = rand_data();
        bt.data = rand_data();
        bt.strb = r[SW-1:0];
        bt.user = '0;
        bt.user[TUSER_DST_LSB +: TUSER_DST_WIDTH] = 8'b0000_0001;
        bt.last = 1'b0;
        s_axis_tdata  = bt.data;
        s_axis_tstrb  = bt.strb;
        s_axis_tuser  = bt.user;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        exp_q[0].push_back(bt);
        step();
        s_axis_tdata = rand_data();
        rst = 1'b1;
        #1;
        chk_eq("mid-pkt reset tvalid", m_axis_tvalid, '0);
        s_axis_tvalid = 1'b0;
        step();
        clear_model();
        chk_eq("mid-pkt reset tvalid held", m_axis_tvalid, '0);
        chk_eq("mid-pkt reset s_axis_tready", s_axis_tready, 1'b0);
        check_counters("mid-pkt reset");
        rst = 1'b0;
        step();
        chk_eq("after reset s_axis_tready", s_axis_tready, 1'b1);
        send_pkt(8'b0000_0001, 3, 5'b00001, 1'b0);
        send_pkt(8'b0000_0001, 5, 5'b00001, 1'b0);
        wait_drain("after reset");
        check_counters("after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
